// File: rtl/lenet_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lenet_layer_sequencer
// Brief   : Walks the LeNet-5 layers, presents per-layer geometry, handshakes
//           start/done with the shared layer datapath under a watchdog.
// Rev     : 1.0
// ============================================================================
module lenet_layer_sequencer #(
    parameter int NUM_LAYERS     = 6,
    parameter int MAX_M          = 784,
    parameter int MAX_K          = 150,
    parameter int MAX_N          = 32,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_run,
    input  logic                     i_abort,
    input  logic                     i_layer_done,
    output logic                     o_layer_start,
    output logic [3:0]               o_layer,
    output logic [3:0]               o_x1,
    output logic [3:0]               o_x2,
    output logic [5:0]               o_x3,
    output logic [5:0]               o_x4,
    output logic [5:0]               o_y1,
    output logic [5:0]               o_y2,
    output logic [5:0]               o_y3,
    output logic [2:0]               o_stride,
    output logic [5:0]               o_next_y1,
    output logic [5:0]               o_next_y2,
    output logic [5:0]               o_next_y3,
    output logic [$clog2(MAX_M):0]   o_m,
    output logic [$clog2(MAX_M):0]   o_mij,
    output logic [$clog2(MAX_M):0]   o_padding_m,
    output logic [$clog2(MAX_K):0]   o_k,
    output logic [$clog2(MAX_N):0]   o_n,
    output logic                     o_busy,
    output logic                     o_net_done,
    output logic                     o_timeout_err
);

    localparam int MW  = $clog2(MAX_M) + 1;
    localparam int KW  = $clog2(MAX_K) + 1;
    localparam int NW  = $clog2(MAX_N) + 1;
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] c_WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_BUSY  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    // Packed ROM word: {X1[4], X2[4], X3[6], X4[6], Y1=Y2[6], Y3[6], sb, pad}
    function automatic logic [33:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_entry = {4'd5, 4'd5, 6'd1,  6'd6,  6'd32, 6'd1,  1'b0, 1'b1};
            4'd1:    rom_entry = {4'd3, 4'd3, 6'd6,  6'd6,  6'd29, 6'd6,  1'b1, 1'b0};
            4'd2:    rom_entry = {4'd5, 4'd5, 6'd6,  6'd16, 6'd14, 6'd6,  1'b0, 1'b1};
            4'd3:    rom_entry = {4'd3, 4'd3, 6'd16, 6'd16, 6'd11, 6'd16, 1'b1, 1'b0};
            4'd4:    rom_entry = {4'd1, 4'd1, 6'd16, 6'd32, 6'd1,  6'd16, 1'b0, 1'b0};
            4'd5:    rom_entry = {4'd1, 4'd1, 6'd32, 6'd10, 6'd1,  6'd32, 1'b0, 1'b0};
            default: rom_entry = '0;
        endcase
    endfunction

    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic [WDW-1:0] r_wdog;
    logic [5:0]     r_mij2;
    logic           r_pad;

    logic           w_last;
    logic           w_wd_hit;
    logic [33:0]    w_rom;
    logic [33:0]    w_rom_nxt;
    logic [5:0]     w_diff1;
    logic [5:0]     w_diff2;
    logic [5:0]     w_mij;
    logic [5:0]     w_mij2;

    assign w_last    = (o_layer == 4'(NUM_LAYERS - 1));
    assign w_wd_hit  = (r_wdog == c_WD_LIMIT);
    assign w_rom     = rom_entry(o_layer);
    assign w_rom_nxt = w_last ? 34'd0 : rom_entry(o_layer + 4'd1);
    assign w_diff1   = w_rom[13:8] - {2'b00, w_rom[33:30]};
    assign w_diff2   = w_rom[13:8] - {2'b00, w_rom[29:26]};
    assign w_mij     = (w_diff1 >> w_rom[1]) + 6'd1;
    assign w_mij2    = (w_diff2 >> w_rom[1]) + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_run) w_state_nxt = S_LOAD;
                S_LOAD:  w_state_nxt = S_CALC;
                S_CALC:  w_state_nxt = S_ISSUE;
                S_ISSUE: w_state_nxt = S_BUSY;
                S_BUSY: begin
                    if (i_layer_done) w_state_nxt = w_last ? S_DONE : S_LOAD;
                    else if (w_wd_hit) w_state_nxt = S_ERR;
                end
                S_DONE:  if (i_run) w_state_nxt = S_LOAD;
                S_ERR:   w_state_nxt = S_ERR;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_layer_start = (r_state == S_ISSUE) && !i_abort;
        o_busy        = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
        o_net_done    = (r_state == S_DONE);
    end

    // Watchdog reads 0 during ISSUE, so reaching the limit lands ERR
    // exactly TIMEOUT_CYCLES clocks after the start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog        <= '0;
            o_layer       <= 4'd0;
            o_timeout_err <= 1'b0;
        end else begin
            r_wdog <= ((r_state == S_ISSUE) || (r_state == S_BUSY)) ? r_wdog + 1'b1 : '0;
            if (i_abort) begin
                o_layer       <= 4'd0;
                o_timeout_err <= 1'b0;
            end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && i_run) begin
                o_layer <= 4'd0;
            end else if ((r_state == S_BUSY) && i_layer_done) begin
                o_layer <= w_last ? 4'(NUM_LAYERS) : o_layer + 4'd1;
            end else if ((r_state == S_BUSY) && w_wd_hit) begin
                o_timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_x1 <= '0;  o_x2 <= '0;  o_x3 <= '0;  o_x4 <= '0;
            o_y1 <= '0;  o_y2 <= '0;  o_y3 <= '0;  o_stride <= '0;
            o_next_y1 <= '0;  o_next_y2 <= '0;  o_next_y3 <= '0;
            o_mij <= '0;  o_m <= '0;  o_padding_m <= '0;  o_k <= '0;  o_n <= '0;
            r_mij2 <= '0;  r_pad <= 1'b0;
        end else if (!i_abort && (r_state == S_LOAD)) begin
            o_x1      <= w_rom[33:30];
            o_x2      <= w_rom[29:26];
            o_x3      <= w_rom[25:20];
            o_x4      <= w_rom[19:14];
            o_y1      <= w_rom[13:8];
            o_y2      <= w_rom[13:8];
            o_y3      <= w_rom[7:2];
            o_stride  <= 3'd1 << w_rom[1];
            o_next_y1 <= w_rom_nxt[13:8];
            o_next_y2 <= w_rom_nxt[13:8];
            o_next_y3 <= w_rom_nxt[7:2];
            o_n       <= NW'(w_rom[19:14]);
            o_mij     <= MW'(w_mij);
            r_mij2    <= w_mij2;
            r_pad     <= w_rom[0];
        end else if (!i_abort && (r_state == S_CALC)) begin
            o_m         <= o_mij * MW'(r_mij2);
            o_padding_m <= (o_mij + MW'(r_pad)) * (MW'(r_mij2) + MW'(r_pad));
            o_k         <= KW'(o_x3) * KW'(o_x2) * KW'(o_x1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lenet_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lenet_layer_sequencer
// Brief   : Scoreboard bench: expected per-layer geometry queued at run,
//           popped and compared on every layer_start.
// Rev     : 1.0
// ============================================================================
module tb_lenet_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_run = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_layer_done = 1'b0;
    logic        o_layer_start;
    logic [3:0]  o_layer, o_x1, o_x2;
    logic [5:0]  o_x3, o_x4, o_y1, o_y2, o_y3, o_next_y1, o_next_y2, o_next_y3;
    logic [2:0]  o_stride;
    logic [10:0] o_m, o_mij, o_padding_m;
    logic [8:0]  o_k;
    logic [5:0]  o_n;
    logic        o_busy, o_net_done, o_timeout_err;

    lenet_layer_sequencer #(.TIMEOUT_CYCLES(64)) u_dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_abort(i_abort),
        .i_layer_done(i_layer_done), .o_layer_start(o_layer_start),
        .o_layer(o_layer), .o_x1(o_x1), .o_x2(o_x2), .o_x3(o_x3), .o_x4(o_x4),
        .o_y1(o_y1), .o_y2(o_y2), .o_y3(o_y3), .o_stride(o_stride),
        .o_next_y1(o_next_y1), .o_next_y2(o_next_y2), .o_next_y3(o_next_y3),
        .o_m(o_m), .o_mij(o_mij), .o_padding_m(o_padding_m), .o_k(o_k), .o_n(o_n),
        .o_busy(o_busy), .o_net_done(o_net_done), .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int layer; int m; int k; int p; int stride; int n; int ny1;
    } exp_t;

    int   c_M[6]   = '{784, 196, 100, 25, 1, 1};
    int   c_K[6]   = '{25, 54, 150, 144, 16, 32};
    int   c_P[6]   = '{841, 196, 121, 25, 1, 1};
    int   c_S[6]   = '{1, 2, 1, 2, 1, 1};
    int   c_N[6]   = '{6, 6, 16, 16, 32, 10};
    int   c_NY[6]  = '{29, 14, 11, 1, 1, 0};

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_count = 0;
    int   last_done_cyc = 0;
    int   withhold = -1;
    bit   resp_en = 1'b0;
    int   s_cyc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_pass(input int nlay);
        for (int i = 0; i < nlay; i++) begin
            exp_t e;
            e.layer = i; e.m = c_M[i]; e.k = c_K[i]; e.p = c_P[i];
            e.stride = c_S[i]; e.n = c_N[i]; e.ny1 = c_NY[i];
            q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel: 0 layer_start, 1 net_done, 2 timeout_err; returns at a negedge
    task automatic wait_for(input int sel, input int budget, input string tag);
        int  n = 0;
        bit  hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = o_layer_start;
                1:       hit = o_net_done;
                default: hit = o_timeout_err;
            endcase
        end
        check_val(tag, 32'(hit), 1);
    endtask

    task automatic wait_start_layer(input int lay);
        for (int i = 0; i < 8; i++) begin
            wait_for(0, 40, "start_wait");
            if (int'(o_layer) == lay) break;
        end
        check_val("start_layer_reached", 32'(o_layer), 32'(lay));
    endtask

    always @(posedge clk) if (!rst) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_layer_start) begin
            start_count++;
            if (q.size() == 0) begin
                check_val("extra_start", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check_val("sb_layer",  32'(o_layer),     32'(mon_e.layer));
                check_val("sb_M",      32'(o_m),         32'(mon_e.m));
                check_val("sb_K",      32'(o_k),         32'(mon_e.k));
                check_val("sb_padM",   32'(o_padding_m), 32'(mon_e.p));
                check_val("sb_stride", 32'(o_stride),    32'(mon_e.stride));
                check_val("sb_N",      32'(o_n),         32'(mon_e.n));
                check_val("sb_nextY1", 32'(o_next_y1),   32'(mon_e.ny1));
            end
        end
    end

    // Datapath model: answers each start 10 clocks later unless withheld
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && o_layer_start && int'(o_layer) != withhold) begin
                repeat (10) @(posedge clk);
                #1;
                i_layer_done  = 1'b1;
                last_done_cyc = cyc;
                @(posedge clk);
                #1;
                i_layer_done = 1'b0;
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        tick(2);
        check_val("rst_layer",   32'(o_layer), 0);
        check_val("rst_start",   32'(o_layer_start), 0);
        check_val("rst_busy",    32'(o_busy), 0);
        check_val("rst_netdone", 32'(o_net_done), 0);
        check_val("rst_terr",    32'(o_timeout_err), 0);
        check_val("rst_cfg",     32'(o_m) | 32'(o_k) | 32'(o_x1) | 32'(o_stride), 0);
        rst = 1'b0;

        // Spurious done in IDLE
        i_layer_done = 1'b1; tick(1); i_layer_done = 1'b0; tick(1);
        check_val("idle_done_busy",  32'(o_busy), 0);
        check_val("idle_done_layer", 32'(o_layer), 0);

        // First pass with latency checks
        push_pass(6);
        while (cyc < 5) tick(1);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        wait_for(0, 20, "first_start");
        check_val("lat_first_start", 32'(cyc), 8);
        i_layer_done = 1'b1; tick(1); i_layer_done = 1'b0;
        check_val("issue_done_layer", 32'(o_layer), 0);
        check_val("issue_done_busy",  32'(o_busy), 1);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        while (cyc < 20) tick(1);
        check_val("busy_run_starts", 32'(start_count), 1);
        i_layer_done = 1'b1; resp_en = 1'b1; tick(1); i_layer_done = 1'b0;
        wait_for(0, 20, "second_start");
        check_val("lat_next_start", 32'(cyc), 23);
        wait_for(1, 200, "pass1_done");
        check_val("netdone_lat",  32'(cyc), 32'(last_done_cyc + 1));
        check_val("pass1_layer",  32'(o_layer), 6);
        check_val("pass1_starts", 32'(start_count), 6);
        check_val("pass1_q",      32'(q.size()), 0);

        // Spurious done in DONE
        i_layer_done = 1'b1; tick(1); i_layer_done = 1'b0; tick(2);
        check_val("done_hold", 32'(o_net_done), 1);
        check_val("done_layer", 32'(o_layer), 6);
        check_val("done_starts", 32'(start_count), 6);

        // Restart from DONE
        push_pass(6);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        wait_for(1, 300, "pass2_done");
        check_val("pass2_layer",  32'(o_layer), 6);
        check_val("pass2_starts", 32'(start_count), 12);
        check_val("pass2_q",      32'(q.size()), 0);

        // abort and layer_done in the same BUSY cycle on L1
        withhold = 1;
        push_pass(2);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        wait_start_layer(1);
        tick(3);
        i_abort = 1'b1; i_layer_done = 1'b1; tick(1);
        i_abort = 1'b0; i_layer_done = 1'b0;
        check_val("abort_busy",  32'(o_busy), 0);
        check_val("abort_layer", 32'(o_layer), 0);
        tick(5);
        check_val("abort_starts", 32'(start_count), 14);

        // Watchdog on L2
        withhold = 2;
        push_pass(3);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        wait_start_layer(2);
        s_cyc = cyc;
        wait_for(2, 200, "wd_err");
        check_val("wd_latency", 32'(cyc), 32'(s_cyc + 64));
        check_val("wd_layer",   32'(o_layer), 2);
        check_val("wd_busy",    32'(o_busy), 0);
        i_run = 1'b1; tick(1); i_run = 1'b0; tick(3);
        check_val("err_hold_terr",  32'(o_timeout_err), 1);
        check_val("err_hold_layer", 32'(o_layer), 2);
        i_abort = 1'b1; tick(1); i_abort = 1'b0;
        check_val("err_abort_terr",  32'(o_timeout_err), 0);
        check_val("err_abort_layer", 32'(o_layer), 0);
        check_val("err_abort_busy",  32'(o_busy), 0);

        // Async reset during BUSY on L3
        withhold = 3;
        push_pass(4);
        i_run = 1'b1; tick(1); i_run = 1'b0;
        wait_start_layer(3);
        tick(3);
        #2 rst = 1'b1;
        #1;
        check_val("arst_layer", 32'(o_layer), 0);
        check_val("arst_busy",  32'(o_busy), 0);
        check_val("arst_cfg",   32'(o_m) | 32'(o_k) | 32'(o_x1) | 32'(o_padding_m) | 32'(o_stride), 0);
        check_val("arst_flags", 32'(o_start_flags()), 0);
        tick(1);
        rst = 1'b0;
        i_layer_done = 1'b1; tick(1); i_layer_done = 1'b0; tick(3);
        check_val("post_rst_busy",   32'(o_busy), 0);
        check_val("post_rst_starts", 32'(start_count), 21);
        check_val("final_q",         32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic [2:0] o_start_flags();
        return {o_layer_start, o_net_done, o_timeout_err};
    endfunction

endmodule
`default_nettype wire

// File: doc/lenet_layer_sequencer.md
# lenet_layer_sequencer

Registered layer scheduler for the LeNet-5 accelerator. It walks the six network layers in order and presents each layer's geometry to the shared `layerX` datapath: X1..X4, Y1..Y3, STRIDE, M, Mij, N, K, padding_M, next_Y*. It issues a one-cycle start pulse per layer and waits for the datapath's done pulse before advancing. A watchdog counter and an abort path keep the sequencer from ever hanging on a stalled layer.

## Interface
- `NUM_LAYERS`, 6: number of layers sequenced, 1..6.
- `MAX_M`, 784: sizes the M/Mij/padding_M outputs as $clog2(MAX_M)+1 bits.
- `MAX_K`, 150: sizes K as $clog2(MAX_K)+1 bits.
- `MAX_N`, 32: sizes N as $clog2(MAX_N)+1 bits.
- `TIMEOUT_CYCLES`, 2^20: watchdog limit, in clocks, while a layer is busy.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run` in 1: single-cycle request to start a full network pass.
- `abort` in 1: forces a return to IDLE.
- `layer_done` in 1: single-cycle done pulse from the datapath.
- `layer_start` out 1: single-cycle start pulse to the datapath.
- `layer` out 4: current layer index (0..NUM_LAYERS-1), or NUM_LAYERS when finished.
- `X1`, `X2` out 4: kernel size.
- `X3`, `X4` out 6: input and output channel counts.
- `Y1`, `Y2`, `Y3` out 6: input map size.
- `STRIDE` out 3: layer stride.
- `next_Y1`, `next_Y2`, `next_Y3` out 6: next layer's input size.
- `M`, `Mij`, `padding_M` out $clog2(MAX_M)+1: derived output-map geometry.
- `K` out $clog2(MAX_K)+1: derived dot-product length.
- `N` out $clog2(MAX_N)+1: derived output channel count.
- `busy` out 1: high outside IDLE, DONE and ERR.
- `net_done` out 1: level; high while in DONE.
- `timeout_err` out 1: sticky watchdog error flag.

## Operation
- Internal ROM, indexed by layer, holds {X1, X2, X3, X4, Y1(=Y2), Y3, sb, pad}:
  - L0 = {5,5,1,6,32,1,0,1}
  - L1 = {3,3,6,6,29,6,1,0}
  - L2 = {5,5,6,16,14,6,0,1}
  - L3 = {3,3,16,16,11,16,1,0}
  - L4 = {1,1,16,32,1,16,0,0}
  - L5 = {1,1,32,10,1,32,0,0}
- next_Y* for a layer is the following layer's Y*. For the last layer, next_Y* = 0.
- Derived values, all unsigned:
  - Mij = ((Y1−X1)>>sb)+1
  - M = Mij·Mij2, where Mij2 uses Y2/X2
  - K = X3·X2·X1
  - N = X4
  - padding_M = (Mij+pad)·(Mij2+pad)
  - STRIDE = 1<<sb
- Expected derived values per layer (M/K/padding_M): L0 784/25/841, L1 196/54/196, L2 100/150/121, L3 25/144/25, L4 1/16/1, L5 1/32/1.
- FSM transitions:
  - IDLE: `run` → LOAD with layer=0.
  - LOAD (1 clk): register ROM fields and compute Mij/Mij2. → CALC.
  - CALC (1 clk): register the products M, K, padding_M. → ISSUE.
  - ISSUE (1 clk): `layer_start`=1, clear watchdog. → BUSY.
  - BUSY: waits for `layer_done`.
    - On `layer_done`, if layer < NUM_LAYERS−1: layer+1 → LOAD.
    - On `layer_done` at the last layer: layer=NUM_LAYERS → DONE.
    - Watchdog reaches TIMEOUT_CYCLES−1 without `layer_done`: → ERR, set `timeout_err`.
  - DONE: holds. `run` → LOAD with layer=0 (restart).
  - ERR: holds all outputs. Only `abort` or `rst` leaves it; `abort` → IDLE.
- `abort` in any state → IDLE next cycle. It clears `timeout_err` and `layer`, and suppresses `layer_start`.
- `abort` has priority over every other event in the same cycle.
- Events ignored:
  - `run` outside IDLE and DONE.
  - `layer_done` outside BUSY, including in ISSUE.
- Config outputs change only in LOAD and CALC. They are stable from ISSUE through the end of BUSY.

## Timing
- Reset values:
  - FSM in IDLE.
  - `layer`=0.
  - All config outputs 0.
  - `layer_start`, `busy`, `net_done`, `timeout_err` = 0.
- `run` at edge t: LOAD at t+1, CALC at t+2, `layer_start` high during t+3.
- Config outputs are valid no later than the cycle in which `layer_start` is high.
- `layer_done` at edge d: LOAD for the next layer at d+1, next `layer_start` at d+3. Per-layer overhead is 3 clocks.
- After the last `layer_done`, `net_done` rises on the next cycle.
- `rst` mid-layer clears everything asynchronously. A `layer_done` pulse that arrives after reset is ignored.

## Test plan
- Full pass:
  - Stimulus: reset, pulse `run`, bench returns `layer_done` 10 clocks after each `layer_start`.
  - Required: 6 start pulses with `layer`=0..5 and M/K/padding_M exactly as tabulated, STRIDE=1,2,1,2,1,1; then `net_done`=1 and `layer`=6.
- Latency:
  - Stimulus: `run` at cycle 5.
  - Required: `layer_start` at cycle 8. A `layer_done` at cycle 20 gives the next `layer_start` at cycle 23.
- Spurious inputs:
  - Stimulus: `layer_done` in IDLE, in ISSUE, and in DONE; `run` during BUSY.
  - Required: no state change, no extra `layer_start`.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=64, withhold `layer_done` on L2.
  - Required: ERR 64 clocks after `layer_start`, `timeout_err`=1, `layer`=2 held. `abort` → IDLE and `timeout_err`=0.
- Abort/reset races:
  - Stimulus: `abort` and `layer_done` in the same BUSY cycle.
  - Required: IDLE, `layer`=0.
  - Stimulus: async `rst` during BUSY on L3.
  - Required: all outputs at reset values immediately.
- Restart:
  - Stimulus: `run` while in DONE.
  - Required: second full pass identical to the first.
